// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg : state/cause encodings and a constant helper for reset_sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        HOLD       = 2'd1,
        PERIPH_REL = 2'd2,
        RUN        = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_LOCK = 2'd1,
        CAUSE_BTN  = 2'd2,
        CAUSE_WDT  = 2'd3
    } cause_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sync_debounce.sv
// ---------------------------------------------------------------------------
// rst_sync_debounce : 2-flop synchronizer plus hold-time debounce, giving a
//                     pressed level and a one-cycle press pulse per assertion
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rst_sync_debounce #(
    parameter int DebounceCycles = 480000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int            DW     = $clog2(DebounceCycles + 1);
    localparam logic [DW-1:0] C_LAST = DW'(DebounceCycles - 1);

    logic          meta_q;
    logic          sync_q;
    logic [DW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            press_q <= 1'b0;
            if (!sync_q) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (cnt_q == C_LAST) begin
                // Counter parks at its last value; the pulse fires only on the rising level.
                if (!level_q) begin
                    press_q <= 1'b1;
                end
                level_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer : PLL-lock qualification, button debounce and ordered
//                   peripheral/core reset release with delayed USB pull-up.
//                   Optional watchdog built when RST_SEQ_WATCHDOG_EN is defined.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int LockStableCycles  = 4800,
    parameter int HoldCycles        = 48000,
    parameter int PeriphLeadCycles  = 480,
    parameter int PullupDelayCycles = 480000,
    parameter int DebounceCycles    = 480000,
    parameter int WatchdogCycles    = 48000000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       pll_locked_i,
    input  logic       btn_reset_i,
    input  logic       wdt_kick_i,
    output logic       core_reset_o,
    output logic       periph_reset_o,
    output logic       usb_pull_en_o,
    output logic       ready_o,
    output logic [1:0] reset_cause_o
);

    localparam int CW = $clog2(max2(max2(LockStableCycles, HoldCycles),
                                    max2(PeriphLeadCycles, PullupDelayCycles)) + 1);

    localparam logic [CW-1:0] C_LOCK_LAST = CW'(LockStableCycles - 1);
    localparam logic [CW-1:0] C_HOLD_LAST = CW'(HoldCycles - 1);
    localparam logic [CW-1:0] C_LEAD_LAST = CW'(PeriphLeadCycles - 1);
    localparam logic [CW-1:0] C_PULL_LAST = CW'(PullupDelayCycles - 1);

    logic          lock_meta_q;
    logic          lock_s_q;
    logic          btn_level;
    logic          btn_press;
    logic          wdt_fire;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          core_rst_q;
    logic          periph_rst_q;
    logic          pull_en_q;
    logic          ready_q;
    cause_e        cause_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    rst_sync_debounce #(
        .DebounceCycles (DebounceCycles)
    ) u_btn (
        .clk_i   (clk_i),
        .rst_ni  (reset_n_i),
        .btn_i   (btn_reset_i),
        .level_o (btn_level),
        .press_o (btn_press)
    );

`ifdef RST_SEQ_WATCHDOG_EN
    localparam int            WW         = $clog2(WatchdogCycles + 1);
    localparam logic [WW-1:0] C_WDT_LAST = WW'(WatchdogCycles - 1);

    logic [WW-1:0] wdt_cnt_q;

    // Outside RUN the counter is held at zero, so every RUN entry starts fresh.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wdt_cnt_q <= '0;
        end else if (state_q != RUN || wdt_kick_i) begin
            wdt_cnt_q <= '0;
        end else if (wdt_cnt_q != C_WDT_LAST) begin
            wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end
    end

    assign wdt_fire = (state_q == RUN) && !wdt_kick_i && (wdt_cnt_q == C_WDT_LAST);
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick_i & (WatchdogCycles > 0);
    assign wdt_fire   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            core_rst_q   <= 1'b1;
            periph_rst_q <= 1'b1;
            pull_en_q    <= 1'b0;
            ready_q      <= 1'b0;
            cause_q      <= CAUSE_POR;
        end else if (!lock_s_q && state_q != WAIT_LOCK) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            core_rst_q   <= 1'b1;
            periph_rst_q <= 1'b1;
            pull_en_q    <= 1'b0;
            ready_q      <= 1'b0;
            cause_q      <= CAUSE_LOCK;
        end else if (btn_press && state_q != WAIT_LOCK) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            core_rst_q   <= 1'b1;
            periph_rst_q <= 1'b1;
            pull_en_q    <= 1'b0;
            ready_q      <= 1'b0;
            cause_q      <= CAUSE_BTN;
        end else if (wdt_fire) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            core_rst_q   <= 1'b1;
            periph_rst_q <= 1'b1;
            pull_en_q    <= 1'b0;
            ready_q      <= 1'b0;
            cause_q      <= CAUSE_WDT;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == C_LOCK_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    // A button still held down keeps the system parked in HOLD.
                    if (btn_level) begin
                        cnt_q <= '0;
                    end else if (cnt_q == C_HOLD_LAST) begin
                        state_q      <= PERIPH_REL;
                        cnt_q        <= '0;
                        periph_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PERIPH_REL: begin
                    if (cnt_q == C_LEAD_LAST) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        core_rst_q <= 1'b0;
                        ready_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q == C_PULL_LAST) begin
                        pull_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign core_reset_o   = core_rst_q;
    assign periph_reset_o = periph_rst_q;
    assign usb_pull_en_o  = pull_en_q;
    assign ready_o        = ready_q;
    assign reset_cause_o  = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer : directed bench for reset_sequencer, params 4/8/4/16/3/32
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reset_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       pll_locked_i;
    logic       btn_reset_i;
    logic       wdt_kick_i = 1'b0;
    logic       core_reset_o;
    logic       periph_reset_o;
    logic       usb_pull_en_o;
    logic       ready_o;
    logic [1:0] reset_cause_o;

    int n_cmp = 0;
    int n_err = 0;
    bit kick_en = 1'b1;

    reset_sequencer #(
        .LockStableCycles  (4),
        .HoldCycles        (8),
        .PeriphLeadCycles  (4),
        .PullupDelayCycles (16),
        .DebounceCycles    (3),
        .WatchdogCycles    (32)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .pll_locked_i   (pll_locked_i),
        .btn_reset_i    (btn_reset_i),
        .wdt_kick_i     (wdt_kick_i),
        .core_reset_o   (core_reset_o),
        .periph_reset_o (periph_reset_o),
        .usb_pull_en_o  (usb_pull_en_o),
        .ready_o        (ready_o),
        .reset_cause_o  (reset_cause_o)
    );

    always #5 clk_i = ~clk_i;

    // Periodic kick every 20 cycles while enabled.
    initial begin
        int kcyc = 0;
        forever begin
            @(posedge clk_i);
            #1;
            kcyc++;
            wdt_kick_i = kick_en && (kcyc % 20 == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_periph_fall(input string tag);
        int k = 0;
        while (periph_reset_o !== 1'b0 && k < 40) begin
            tick(1);
            k++;
        end
        chk(tag, 8'(k < 40), 8'd1);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        pll_locked_i = 1'b1;
        btn_reset_i  = 1'b0;
        tick(2);
        chk("rst_core",   8'(core_reset_o),   8'd1);
        chk("rst_periph", 8'(periph_reset_o), 8'd1);
        chk("rst_pull",   8'(usb_pull_en_o),  8'd0);
        chk("rst_ready",  8'(ready_o),        8'd0);
        chk("rst_cause",  8'(reset_cause_o),  8'd0);

        // Power-on: HOLD after 6, periph at +8, core at +4, pull-up at +16.
        reset_n_i = 1'b1;
        tick(13);
        chk("por_periph_e13", 8'(periph_reset_o), 8'd1);
        tick(1);
        chk("por_periph_e14", 8'(periph_reset_o), 8'd0);
        chk("por_core_e14",   8'(core_reset_o),   8'd1);
        tick(3);
        chk("por_core_e17",   8'(core_reset_o),   8'd1);
        tick(1);
        chk("por_core_e18",   8'(core_reset_o),   8'd0);
        chk("por_ready_e18",  8'(ready_o),        8'd1);
        chk("por_pull_e18",   8'(usb_pull_en_o),  8'd0);
        tick(15);
        chk("por_pull_e33",   8'(usb_pull_en_o),  8'd0);
        tick(1);
        chk("por_pull_e34",   8'(usb_pull_en_o),  8'd1);
        chk("por_cause",      8'(reset_cause_o),  8'd0);
        tick(60);
        chk("pull_saturate",  8'(usb_pull_en_o),  8'd1);
        chk("run_ready_long", 8'(ready_o),        8'd1);

        // Lock loss in RUN.
        pll_locked_i = 1'b0;
        tick(3);
        chk("loss_ready",  8'(ready_o),        8'd0);
        chk("loss_core",   8'(core_reset_o),   8'd1);
        chk("loss_periph", 8'(periph_reset_o), 8'd1);
        chk("loss_pull",   8'(usb_pull_en_o),  8'd0);
        chk("loss_cause",  8'(reset_cause_o),  8'd1);

        // Lock glitch in WAIT_LOCK restarts the stable count.
        pll_locked_i = 1'b1;
        tick(3);
        pll_locked_i = 1'b0;
        tick(1);
        pll_locked_i = 1'b1;
        tick(9);
        chk("glitch_periph_e13", 8'(periph_reset_o), 8'd1);
        tick(4);
        chk("glitch_periph_e17", 8'(periph_reset_o), 8'd1);
        tick(1);
        chk("glitch_periph_e18", 8'(periph_reset_o), 8'd0);
        tick(4);
        chk("glitch_core_e22",   8'(core_reset_o),   8'd0);
        tick(16);
        chk("glitch_pull_e38",   8'(usb_pull_en_o),  8'd1);

        // Short bounce is not a press.
        btn_reset_i = 1'b1;
        tick(2);
        btn_reset_i = 1'b0;
        tick(10);
        chk("bounce_ready", 8'(ready_o),       8'd1);
        chk("bounce_cause", 8'(reset_cause_o), 8'd1);

        // Held press re-enters HOLD.
        btn_reset_i = 1'b1;
        tick(5);
        chk("btn_ready_e5", 8'(ready_o), 8'd1);
        btn_reset_i = 1'b0;
        tick(1);
        chk("btn_ready_e6",  8'(ready_o),        8'd0);
        chk("btn_core_e6",   8'(core_reset_o),   8'd1);
        chk("btn_periph_e6", 8'(periph_reset_o), 8'd1);
        chk("btn_pull_e6",   8'(usb_pull_en_o),  8'd0);
        chk("btn_cause",     8'(reset_cause_o),  8'd2);
        kick_en = 1'b0;
        wait_periph_fall("btn_periph_timeout");
        tick(3);
        chk("btn_core_p3", 8'(core_reset_o), 8'd1);
        tick(1);
        chk("btn_core_p4", 8'(core_reset_o), 8'd0);
        chk("btn_ready",   8'(ready_o),      8'd1);
        tick(15);
        chk("btn_pull_15", 8'(usb_pull_en_o), 8'd0);
        tick(1);
        chk("btn_pull_16", 8'(usb_pull_en_o), 8'd1);

`ifdef RST_SEQ_WATCHDOG_EN
        tick(15);
        chk("wdt_ready_31", 8'(ready_o),       8'd1);
        tick(1);
        chk("wdt_ready_32", 8'(ready_o),       8'd0);
        chk("wdt_cause",    8'(reset_cause_o), 8'd3);
        kick_en = 1'b1;
        wait_periph_fall("wdt_periph_timeout");
        tick(4);
        chk("kick_core", 8'(core_reset_o), 8'd0);
        tick(100);
        chk("kick_ready", 8'(ready_o),       8'd1);
        chk("kick_cause", 8'(reset_cause_o), 8'd3);
`else
        tick(16);
        chk("nowdt_ready_32",  8'(ready_o),       8'd1);
        tick(100);
        chk("nowdt_ready_132", 8'(ready_o),       8'd1);
        chk("nowdt_cause",     8'(reset_cause_o), 8'd2);
        kick_en = 1'b1;
`endif

        // Lock loss and press reach the FSM on the same cycle.
        btn_reset_i = 1'b1;
        tick(3);
        pll_locked_i = 1'b0;
        tick(3);
        chk("simul_core",  8'(core_reset_o),  8'd1);
        chk("simul_ready", 8'(ready_o),       8'd0);
        chk("simul_cause", 8'(reset_cause_o), 8'd1);
        btn_reset_i  = 1'b0;
        pll_locked_i = 1'b1;

        // Asynchronous reset in the middle of PERIPH_REL.
        wait_periph_fall("prel_periph_timeout");
        tick(2);
        chk("prel_core",  8'(core_reset_o),  8'd1);
        chk("prel_cause", 8'(reset_cause_o), 8'd1);
        reset_n_i = 1'b0;
        #1;
        chk("arst_core",   8'(core_reset_o),   8'd1);
        chk("arst_periph", 8'(periph_reset_o), 8'd1);
        chk("arst_pull",   8'(usb_pull_en_o),  8'd0);
        chk("arst_ready",  8'(ready_o),        8'd0);
        chk("arst_cause",  8'(reset_cause_o),  8'd0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
